// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package adder_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle between a producer/consumer and the controller.
interface nibble_serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  // Producer and consumer side.
  modport master (
    output in_valid, sub, a, b, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  // Controller side.
  modport slave (
    input  in_valid, sub, a, b, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl_adder4.sv
// 4-bit ripple-carry adder slice, purely combinational.
module adder4
  import adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c_out
);

  logic [NIBBLE_W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single 4-bit slice,
// with valid/ready handshakes on operands and result.
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                        clk,
  input logic                        rst_n,
  nibble_serial_adder_ctrl_if.slave  bus
);

  localparam int unsigned N       = WIDTH / NIBBLE_W;
  localparam int unsigned IdxW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  state_e              state_q;
  logic [IdxW-1:0]     idx_q;
  logic                carry_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    sum_q;
  logic                c_out_q;
  logic                overflow_q;
  logic                out_valid_q;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_c;
  logic                accept;

  // A result being drained in the same cycle frees the controller for new operands.
  assign bus.in_ready  = (state_q == StIdle) || ((state_q == StHold) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.overflow  = overflow_q;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  adder4 u_adder4 (
    .a     (a_nib),
    .b     (b_nib),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      // b_q holds the effective operand; the carry-in of 1 completes two's complement.
      a_q         <= bus.a;
      b_q         <= bus.b ^ {WIDTH{bus.sub}};
      carry_q     <= bus.sub;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      state_q     <= StRun;
    end else begin
      unique case (state_q)
        StIdle: ;
        StRun: begin
          for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IdxW'(i)) begin
              sum_q[i*NIBBLE_W +: NIBBLE_W] <= slice_sum;
            end
          end
          carry_q <= slice_c;
          if (idx_q == LastIdx) begin
            c_out_q     <= slice_c;
            overflow_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                           (slice_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
            out_valid_q <= 1'b1;
            state_q     <= StHold;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed self-checking bench for nibble_serial_adder_ctrl at WIDTH=16.
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until out_valid rises; bounded so a stuck DUT still reaches the summary.
  task automatic wait_result(input string tag, input int exp_lat);
    int cyc;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check({tag, " latency"}, cyc, exp_lat);
  endtask

  task automatic check_result(input string tag, input logic [15:0] exp_sum,
                              input logic exp_c, input logic exp_ov);
    check({tag, " sum"}, {16'h0, bus.sum}, {16'h0, exp_sum});
    check({tag, " c_out"}, {31'h0, bus.c_out}, {31'h0, exp_c});
    check({tag, " overflow"}, {31'h0, bus.overflow}, {31'h0, exp_ov});
  endtask

  task automatic accept_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic sub);
    bus.a        = a;
    bus.b        = b;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    #1;
    check({tag, " in_ready"}, {31'h0, bus.in_ready}, 32'h1);
    step();
    bus.in_valid = 1'b0;
    bus.a        = 16'hdead;
    bus.b        = 16'hbeef;
    bus.sub      = 1'b0;
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, " out_valid drop"}, {31'h0, bus.out_valid}, 32'h0);
    check({tag, " in_ready idle"}, {31'h0, bus.in_ready}, 32'h1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic [15:0] exp_sum, input logic exp_c,
                        input logic exp_ov);
    accept_op(tag, a, b, sub);
    wait_result(tag, 4);
    check_result(tag, exp_sum, exp_c, exp_ov);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sub       = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    #12;
    check("reset in_ready", {31'h0, bus.in_ready}, 32'h1);
    check("reset out_valid", {31'h0, bus.out_valid}, 32'h0);
    check_result("reset", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    run_op("add1", 16'h1234, 16'h0fff, 1'b0, 16'h2233, 1'b0, 1'b0);
    drain("add1");
    run_op("add2", 16'hffff, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    drain("add2");
    run_op("add3", 16'h7fff, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    drain("add3");
    run_op("sub1", 16'h8000, 16'h0001, 1'b1, 16'h7fff, 1'b1, 1'b1);
    drain("sub1");
    run_op("sub2", 16'h0003, 16'h0005, 1'b1, 16'hfffe, 1'b0, 1'b0);

    // Stall in HOLD with a competing request that must be ignored.
    bus.in_valid = 1'b1;
    bus.a        = 16'h5555;
    bus.b        = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold in_ready", {31'h0, bus.in_ready}, 32'h0);
      step();
      check("hold out_valid", {31'h0, bus.out_valid}, 32'h1);
      check_result("hold", 16'hfffe, 1'b0, 1'b0);
    end

    // Drain and accept on the same edge.
    bus.out_ready = 1'b1;
    bus.a         = 16'h0001;
    bus.b         = 16'h0001;
    bus.sub       = 1'b0;
    #1;
    check("b2b in_ready", {31'h0, bus.in_ready}, 32'h1);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b out_valid drop", {31'h0, bus.out_valid}, 32'h0);
    check("b2b busy", {31'h0, bus.in_ready}, 32'h0);
    wait_result("b2b", 4);
    check_result("b2b", 16'h0002, 1'b0, 1'b0);
    drain("b2b");

    // Reset while the third nibble is about to be processed.
    accept_op("rst", 16'h1234, 16'h1111, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("rst in_ready", {31'h0, bus.in_ready}, 32'h1);
    check("rst out_valid", {31'h0, bus.out_valid}, 32'h0);
    check_result("rst", 16'h0000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    step();
    check("rst stays idle", {31'h0, bus.out_valid}, 32'h0);
    run_op("post_rst", 16'h00ff, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
